csa_accumulator: RTL and testbench
==================================

Name: csa_accumulator

Overview:
- Downstream consumer of the carry_save_adder output format: a multi-operand accumulator.
- Streams N-bit operands in, keeps a redundant running total as a (sum, carry) register pair, and compresses one operand per cycle with a 3:2 step.
- On the last operand of a frame, resolves the redundant pair with a chunked carry-propagate adder over several cycles.
- Presents the binary result on a valid/ready output.

Parameters:
- N, 6, operand width.
- ACC_W, 10, accumulator/result width. Must satisfy ACC_W > N.
- CHUNK, 2, bits resolved per cycle. ACC_W % CHUNK must be 0.
- Derived: NCH = ACC_W/CHUNK (5); CW = ACC_W-N+1 (5).

Ports:
- clk  in  1  clock; all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operand present.
- in_ready  out  1  block accepts operand.
- in_data  in  N  unsigned operand.
- in_last  in  1  qualifies in_data as final operand of frame.
- out_valid  out  1  result available.
- out_ready  in  1  consumer takes result.
- out_data  out  ACC_W  frame sum modulo 2**ACC_W.
- out_count  out  CW  operands in frame, saturating at 2**CW-1.
- out_ovf  out  1  frame exceeded 2**(ACC_W-N) operands; sum may have wrapped.

Behaviour:
- Reset (async, immediate):
  - state=ACCUM; s=c=0; count=0; ovf=0; chunk index k=0; resolve carry rc=0; result=0.
  - Outputs: in_ready=1, out_valid=0, out_data=0, out_count=0, out_ovf=0.
  - Reset asserted in any state aborts the frame; no partial result is emitted.
- States: ACCUM, RESOLVE, OUTPUT. in_ready=(state==ACCUM); out_valid=(state==OUTPUT). Both are decoded from registered state only.
- ACCUM, on in_valid&&in_ready, with x = zero-extended in_data:
  - s <= s^c^x.
  - c <= ((s&c)|(s&x)|(c&x))<<1, truncated to ACC_W (MSB carry dropped, i.e. mod 2**ACC_W).
  - count <= count+1, saturating.
  - ovf <= ovf | (count+1 > 2**(ACC_W-N)), sticky.
  - If in_last: k<=0, rc<=0, state<=RESOLVE. The last operand is compressed in the same edge.
  - in_valid low: hold all state.
- RESOLVE: in_ready=0.
  - Each edge: {rc, result[k*CHUNK +: CHUNK]} <= s[k*CHUNK +: CHUNK] + c[k*CHUNK +: CHUNK] + rc; then k<=k+1.
  - After chunk NCH-1: state<=OUTPUT. The final rc is discarded.
  - in_valid/in_data are ignored; no operand is lost because in_ready=0.
- OUTPUT:
  - out_data=result, out_count=count, out_ovf=ovf, all held stable while out_ready is low.
  - On out_ready: s,c,count,ovf <= 0 and state<=ACCUM. in_ready rises the next cycle; there is no same-cycle bypass.
  - out_ready high outside OUTPUT has no effect.
- Latency: last operand accepted at edge E, out_valid high after edge E+NCH (5 cycles default).
- Throughput: one operand/cycle within a frame; NCH+1 dead cycles minimum between frames.
- Arithmetic: out_data == (sum of frame operands) mod 2**ACC_W, exact when the frame has at most 2**(ACC_W-N) operands (16 default).
- Boundaries:
  - A single-operand frame (in_last on the first beat) is legal.
  - An empty frame is impossible.
  - Count saturates at 31 while ovf stays 1.
  - out_data, out_count and out_ovf retain their last values after leaving OUTPUT, until overwritten. Consumers qualify them with out_valid.

Test Plan:
- Reset mid-RESOLVE: frame {63,63}, assert rst 2 cycles after in_last -> out_valid never rises. After release, in_ready=1 and frame {5} gives out_data=5, out_count=1.
- Frame {63,63,63}, out_ready=1 -> out_data=189, out_count=3, out_ovf=0. out_valid high exactly 5 edges after last accept, for one cycle.
- Capacity: 16x 63 -> out_data=1008, out_ovf=0. Then 17x 63 -> out_data=47 (1071 mod 1024), out_count=17, out_ovf=1.
- Backpressure: frame {1,2,3}, hold out_ready=0 for 10 cycles while driving in_valid=1 -> out_data=6 stable, in_ready=0, nothing accepted. Release -> next frame {10} yields 10 (no leakage of ignored beats).
- Gapped input: frame {7,0,9} with in_valid low 3 cycles between beats -> out_data=16, out_count=3.
- Random: 500 frames, lengths 1-20, random operands, random in_valid/out_ready -> every result equals the reference model (sum mod 1024, count, ovf).

Source files
------------

// File: rtl/csa_accumulator.sv
// Multi-operand accumulator: 3:2-compresses one operand per cycle into a redundant (s, c) pair, then resolves it chunk by chunk.
// Latency: the last operand is accepted at edge E and out_valid is high after edge E+NCH. Throughput is one operand per cycle within a frame.
// Backpressure: in_ready is low while a frame is being resolved or its result is held. The result is held stable until out_ready is seen.
//
// Ports:
//   clk, rst            clock and asynchronous active-high reset
//   in_valid/in_ready   operand handshake; in_data is N-bit unsigned, in_last marks the final operand of a frame
//   out_valid/out_ready result handshake
//   out_data            frame sum mod 2**ACC_W
//   out_count           operands in the frame, saturating at 2**CW-1
//   out_ovf             the frame had more than 2**(ACC_W-N) operands, so the sum may have wrapped
module csa_accumulator #(
    parameter int N     = 6,
    parameter int ACC_W = 10,
    parameter int CHUNK = 2,
    localparam int CW   = ACC_W - N + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_data,
    output logic [CW-1:0]    out_count,
    output logic             out_ovf
);

    localparam int NCH = ACC_W / CHUNK;
    localparam int KW  = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [KW-1:0] K_LAST  = KW'(NCH - 1);
    localparam logic [CW:0]   CAP     = (CW + 1)'(2 ** (ACC_W - N));
    localparam logic [CW-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {ACCUM, RESOLVE, OUTPUT} state_t;

    state_t           state, state_nxt;
    logic [ACC_W-1:0] s, c, x;
    logic [ACC_W-1:0] result;
    logic [CW-1:0]    count;
    logic [CW-1:0]    count_q;
    logic             ovf, ovf_q;
    logic [KW-1:0]    k;
    logic             rc;
    logic             accept;
    logic [CW:0]      count_inc;
    logic [CHUNK-1:0] s_chunk, c_chunk;
    logic [CHUNK:0]   chunk_sum;

    // Handshake signals are decoded from the registered state only.
    assign in_ready  = (state == ACCUM);
    assign out_valid = (state == OUTPUT);
    assign out_data  = result;
    assign out_count = count_q;
    assign out_ovf   = ovf_q;

    assign accept    = in_valid && in_ready;
    assign x         = {{(ACC_W - N){1'b0}}, in_data};
    // One bit wider than count, so the overflow test is not affected by saturation.
    assign count_inc = {1'b0, count} + (CW + 1)'(1);

    assign s_chunk   = s[int'(k) * CHUNK +: CHUNK];
    assign c_chunk   = c[int'(k) * CHUNK +: CHUNK];
    assign chunk_sum = {1'b0, s_chunk} + {1'b0, c_chunk} + {{CHUNK{1'b0}}, rc};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ACCUM;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ACCUM:   if (accept && in_last) state_nxt = RESOLVE;
            RESOLVE: if (k == K_LAST)       state_nxt = OUTPUT;
            OUTPUT:  if (out_ready)         state_nxt = ACCUM;
            default:                        state_nxt = ACCUM;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s       <= '0;
            c       <= '0;
            count   <= '0;
            ovf     <= 1'b0;
            k       <= '0;
            rc      <= 1'b0;
            result  <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            case (state)
                ACCUM: begin
                    if (accept) begin
                        s <= s ^ c ^ x;
                        // The carry out of the MSB is dropped, so the total wraps mod 2**ACC_W.
                        c <= ((s & c) | (s & x) | (c & x)) << 1;
                        if (count != CNT_MAX) count <= count + CW'(1);
                        if (count_inc > CAP)  ovf   <= 1'b1;
                        if (in_last) begin
                            k  <= '0;
                            rc <= 1'b0;
                        end
                    end
                end
                RESOLVE: begin
                    // Ripple one chunk per cycle. The carry out of the top chunk is discarded.
                    result[int'(k) * CHUNK +: CHUNK] <= chunk_sum[CHUNK-1:0];
                    rc <= chunk_sum[CHUNK];
                    k  <= k + KW'(1);
                    // Snapshot the frame metadata so the outputs survive the clear in OUTPUT.
                    if (k == K_LAST) begin
                        count_q <= count;
                        ovf_q   <= ovf;
                    end
                end
                OUTPUT: begin
                    if (out_ready) begin
                        s     <= '0;
                        c     <= '0;
                        count <= '0;
                        ovf   <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_csa_accumulator.sv
// Testbench for csa_accumulator: directed frames with literal expectations plus a frame-level reference model.
// Latency: the model expects out_valid NCH edges after the last operand is accepted.
// Backpressure: out_ready is stalled by directed holds and driven randomly in the random phase.
module tb_csa_accumulator;

    localparam int N = 6, ACC_W = 10, CHUNK = 2, NCH = 5, CW = 5;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid, in_ready, in_last;
    logic [N-1:0]     in_data;
    logic             out_valid, out_ready, out_ovf;
    logic [ACC_W-1:0] out_data;
    logic [CW-1:0]    out_count;

    csa_accumulator #(.N(N), .ACC_W(ACC_W), .CHUNK(CHUNK)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_count(out_count), .out_ovf(out_ovf)
    );

    always #5 clk = ~clk;

    int     checks = 0;
    int     errors = 0;
    longint cyc = 0;
    longint last_acc_cyc = 0;
    bit     rnd_on = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input longint got, input longint exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Frame-level reference model: a plain integer sum and operand count per frame.
    // The value of a frame becomes due NCH edges after its last operand is accepted.
    typedef struct {
        int     data;
        int     cnt;
        bit     ovf;
        longint due;
    } res_t;

    res_t exp_q[$];
    int   m_sum = 0;
    int   m_n = 0;
    bit   idle = 1;

    always @(negedge clk) begin
        bit   exp_vld;
        res_t r;
        if (rst) begin
            m_sum = 0;
            m_n   = 0;
            idle  = 1;
            exp_q.delete();
        end else begin
            exp_vld = (exp_q.size() > 0) && (cyc >= exp_q[0].due);
            chk("in_ready", in_ready, idle);
            chk("out_valid", out_valid, exp_vld);
            if (out_valid && exp_vld) begin
                chk("out_data", out_data, exp_q[0].data);
                chk("out_count", out_count, exp_q[0].cnt);
                chk("out_ovf", out_ovf, exp_q[0].ovf);
            end
            if (in_valid && idle) begin
                m_sum += int'(in_data);
                m_n++;
                if (in_last) begin
                    r.data = m_sum % (1 << ACC_W);
                    r.cnt  = (m_n > 31) ? 31 : m_n;
                    r.ovf  = (m_n > (1 << (ACC_W - N)));
                    r.due  = cyc + 1 + NCH;
                    exp_q.push_back(r);
                    idle  = 0;
                    m_sum = 0;
                    m_n   = 0;
                end
            end
            if (exp_vld && out_ready) begin
                void'(exp_q.pop_front());
                idle = 1;
            end
        end
    end

    // Drive one beat after an optional idle gap, and hold it until an edge where in_ready was high.
    // The task is called and returns at posedge+1.
    task automatic send_beat(input int d, input bit last, input int gap);
        int t;
        bit took;
        in_valid = 0;
        in_last  = 0;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
        in_valid = 1;
        in_data  = N'(d);
        in_last  = last;
        took = 0;
        t    = 0;
        while (!took && t < 300) begin
            @(negedge clk);
            took = in_ready;
            @(posedge clk);
            #1;
            t++;
        end
        if (!took) chk("send_timeout", 0, 1);
        last_acc_cyc = cyc;
        in_valid = 0;
        in_last  = 0;
    endtask

    // Wait for out_valid and capture the result. If out_ready is low, stall `hold` more cycles and then pulse it.
    task automatic get_result(output int d, output int cn, output int o, output longint vcyc, input int hold);
        int t;
        @(negedge clk);
        t = 0;
        while (!out_valid && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (!out_valid) chk("result_timeout", 0, 1);
        vcyc = cyc;
        d    = int'(out_data);
        cn   = int'(out_count);
        o    = int'(out_ovf);
        if (!out_ready) begin
            repeat (hold) @(posedge clk);
            @(posedge clk);
            #1;
            out_ready = 1;
            in_valid  = 0;
            in_last   = 0;
            @(posedge clk);
            #1;
            out_ready = 0;
        end else begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_same(input int d, input int len);
        for (int i = 0; i < len; i++) send_beat(d, i == len - 1, 0);
    endtask

    initial begin
        #800000;
        $display("FAIL watchdog got=%0d exp=0 (time limit)", cyc);
        errors++;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int     d, cn, o;
        longint vc;
        rst       = 1;
        in_valid  = 0;
        in_data   = '0;
        in_last   = 0;
        out_ready = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_count", out_count, 0);
        chk("rst_out_ovf", out_ovf, 0);
        @(posedge clk);
        #1;
        rst = 0;

        // Reset during RESOLVE aborts the frame without a result.
        send_beat(63, 0, 0);
        send_beat(63, 1, 0);
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        rst = 1;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        rst = 0;
        repeat (8) begin
            @(negedge clk);
            chk("abort_no_valid", out_valid, 0);
        end
        chk("abort_in_ready", in_ready, 1);
        @(posedge clk);
        #1;
        send_beat(5, 1, 0);
        get_result(d, cn, o, vc, 0);
        chk("single_data", d, 5);
        chk("single_count", cn, 1);

        // out_ready held high: the result appears 5 edges after the last accept, for one cycle only.
        out_ready = 1;
        send_same(63, 3);
        get_result(d, cn, o, vc, 0);
        chk("f189_data", d, 189);
        chk("f189_count", cn, 3);
        chk("f189_ovf", o, 0);
        chk("f189_latency", vc - last_acc_cyc, 5);
        @(negedge clk);
        chk("f189_one_cycle", out_valid, 0);
        @(posedge clk);
        #1;
        out_ready = 0;

        // Frame capacity edge, one operand past it, and count saturation.
        send_same(63, 16);
        get_result(d, cn, o, vc, 0);
        chk("cap16_data", d, 1008);
        chk("cap16_count", cn, 16);
        chk("cap16_ovf", o, 0);
        send_same(63, 17);
        get_result(d, cn, o, vc, 0);
        chk("cap17_data", d, 47);
        chk("cap17_count", cn, 17);
        chk("cap17_ovf", o, 1);
        send_same(1, 35);
        get_result(d, cn, o, vc, 0);
        chk("sat_data", d, 35);
        chk("sat_count", cn, 31);
        chk("sat_ovf", o, 1);

        // Backpressure: in_valid held with a tempting beat while the result waits.
        send_beat(1, 0, 0);
        send_beat(2, 0, 0);
        send_beat(3, 1, 0);
        in_valid = 1;
        in_data  = 6'd50;
        in_last  = 1;
        get_result(d, cn, o, vc, 10);
        chk("bp_data", d, 6);
        chk("bp_count", cn, 3);
        send_beat(10, 1, 0);
        get_result(d, cn, o, vc, 0);
        chk("bp_next_data", d, 10);
        chk("bp_next_count", cn, 1);

        // Gaps between beats.
        send_beat(7, 0, 0);
        send_beat(0, 0, 3);
        send_beat(9, 1, 3);
        get_result(d, cn, o, vc, 0);
        chk("gap_data", d, 16);
        chk("gap_count", cn, 3);

        // Random frames, gaps and out_ready. The model checks every cycle.
        rnd_on = 1;
        fork
            while (rnd_on) begin
                @(posedge clk);
                #1;
                out_ready = ($urandom_range(0, 1) == 1);
            end
        join_none
        for (int f = 0; f < 500; f++) begin
            int len;
            len = $urandom_range(1, 20);
            for (int i = 0; i < len; i++)
                send_beat($urandom_range(0, 63), i == len - 1,
                          ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0);
        end
        rnd_on = 0;
        repeat (3) @(posedge clk);
        #1;
        out_ready = 1;
        repeat (20) @(posedge clk);
        @(negedge clk);
        chk("drain_pending", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
